avmm_frame_writer: RTL and testbench
====================================

Name: avmm_frame_writer

Overview:
Parametrised Avalon-MM rectangle fill engine for the SDRAM pixel buffer. A host (PCIe) programs a CSR bank through the slave port. A start command then makes the master port write a WIDTH x HEIGHT pixel rectangle at BASE, with a programmable row stride. It reports busy, done, a pixel count and an interrupt. It is the generalised successor of the fixed-colour, fixed-range SDRAM writer.

Parameters:
MASTER_ADDRESSWIDTH, 32, byte address width of the master port
SLAVE_ADDRESSWIDTH, 3, CSR word address width (8 registers)
DATAWIDTH, 32, data width of both ports; one pixel per beat
DIMWIDTH, 11, width of the WIDTH/HEIGHT counters (max 2047 pixels)
BYTES_PER_BEAT, 4, master address increment per pixel

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous, active-low reset
slave_address  in  SLAVE_ADDRESSWIDTH  CSR word index
slave_writedata  in  DATAWIDTH  CSR write data
slave_write  in  1  CSR write strobe
slave_read  in  1  CSR read strobe
slave_chipselect  in  1  slave select; qualifies read and write
slave_readdata  out  DATAWIDTH  CSR read data, registered
master_address  out  MASTER_ADDRESSWIDTH  byte address of the current pixel
master_writedata  out  DATAWIDTH  pixel data
master_write  out  1  write request
master_waitrequest  in  1  interconnect stall
irq  out  1  level interrupt = done & irq_en
busy  out  1  fill in progress (for display/debug)

Behaviour:
- Reset: all CSRs 0, slave_readdata 0, master_write 0, master_address 0, master_writedata 0, irq 0, busy 0, FSM IDLE.
- CSR map (word addresses):
  - 0 CTRL: bit0 START (write-1 pulse, reads 0); bit1 ABORT (write-1 pulse, reads 0); bit2 IRQ_EN (R/W).
  - 1 STATUS: bit0 BUSY (RO); bit1 DONE (sticky, write 1 to clear).
  - 2 BASE, 3 STRIDE (bytes), 4 WIDTH, 5 HEIGHT, 6 PIXEL: R/W.
  - 7 COUNT: RO, pixels accepted in the current or last fill.
  - WIDTH/HEIGHT use bits [DIMWIDTH-1:0]; upper bits read 0.
- Slave timing: read has fixed latency 1 (data valid the cycle after slave_read & slave_chipselect). Writes take effect the next cycle. Strobes without chipselect are ignored.
- Start: START while IDLE latches BASE/STRIDE/WIDTH/HEIGHT/PIXEL into working registers, clears COUNT and DONE, and enters WRITE. START while busy is ignored. CSR writes during a fill do not affect it.
- Zero size: WIDTH==0 or HEIGHT==0 goes IDLE->DONE with no master beats. DONE is set 1 cycle after START.
- FSM states: IDLE, WRITE, FINISH.
  - WRITE: master_write=1, master_address=row_base+x*BYTES_PER_BEAT, master_writedata=pixel.
  - Address and data stay stable while master_waitrequest=1. A beat is accepted on the first cycle with master_write & !master_waitrequest.
  - On accept: COUNT++ and x++. At x==WIDTH-1, x=0, y++, row_base+=STRIDE.
  - Accepting the beat at (WIDTH-1, HEIGHT-1) moves to FINISH.
  - FINISH (1 cycle): master_write=0, DONE=1, then IDLE.
- Throughput: 1 pixel/cycle with no stall. Total beats = WIDTH*HEIGHT. Writes are contiguous; master_write never drops between beats.
- Abort: ABORT during WRITE is registered as pending. The current beat completes; master_write is never withdrawn while waitrequest=1. After the next accept, the FSM goes to FINISH with DONE=1 and COUNT holding the accepted total. ABORT while IDLE does nothing.
- Simultaneous DONE set (FINISH) and W1C clear in the same cycle: the set wins.
- Address arithmetic is modulo 2^MASTER_ADDRESSWIDTH; wrap is silent. STRIDE < WIDTH*BYTES_PER_BEAT is legal (rows overlap).
- Asynchronous reset mid-fill: master_write drops immediately and all state returns to reset values.

Optional Feature:
GRADIENT_FILL_EN:
- Defined: CTRL bit3 GRAD (R/W) is added. With GRAD=1, writedata = PIXEL + x + (y<<8) modulo 2^DATAWIDTH.
- Undefined: bit3 reads 0, writes to it are ignored, and writedata = PIXEL for every beat.

Test Plan:
- CSR R/W: write BASE=0x08000000 then read -> readdata 0x08000000 one cycle after the read. Read CTRL after START -> bit0=0.
- Basic fill: BASE=0x08000000, STRIDE=0x10, WIDTH=3, HEIGHT=2, PIXEL=0x0000FF00, no waitrequest -> 6 beats at 0x08000000/04/08/10/14/18, all 0x0000FF00. Then DONE=1, COUNT=6.
- Waitrequest: hold waitrequest high 3 cycles on beat 2 -> address/data stable for those cycles, no skipped or duplicated beat, COUNT=6.
- Abort: WIDTH=100, HEIGHT=1, ABORT after 10 accepts while stalled -> that beat completes, no further beats, DONE=1, COUNT=11, busy=0.
- Zero/busy: HEIGHT=0 START -> DONE set, 0 beats. START during a fill -> ignored, beat total unchanged. IRQ_EN=1 -> irq=1 until DONE is cleared by W1C.
- Reset: assert reset_n low mid-fill -> master_write=0 immediately, STATUS reads 0 after release.

Source files
------------

// File: rtl/avmm_frame_writer.sv
// avmm_frame_writer: Avalon-MM rectangle fill engine with CSR slave and pixel master.
// Optional macro GRADIENT_FILL_EN adds CTRL.GRAD (writedata = PIXEL + x + (y<<8)).
`default_nettype none

module avmm_frame_writer #(
  parameter int MASTER_ADDRESSWIDTH = 32,
  parameter int SLAVE_ADDRESSWIDTH  = 3,
  parameter int DATAWIDTH           = 32,
  parameter int DIMWIDTH            = 11,
  parameter int BYTES_PER_BEAT      = 4
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [SLAVE_ADDRESSWIDTH-1:0]  slave_address,
  input  logic [DATAWIDTH-1:0]           slave_writedata,
  input  logic                           slave_write,
  input  logic                           slave_read,
  input  logic                           slave_chipselect,
  output logic [DATAWIDTH-1:0]           slave_readdata,
  output logic [MASTER_ADDRESSWIDTH-1:0] master_address,
  output logic [DATAWIDTH-1:0]           master_writedata,
  output logic                           master_write,
  input  logic                           master_waitrequest,
  output logic                           irq,
  output logic                           busy
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WRITE = 2'd1, S_FINISH = 2'd2} state_t;

  localparam logic [SLAVE_ADDRESSWIDTH-1:0] A_CTRL   = SLAVE_ADDRESSWIDTH'(0);
  localparam logic [SLAVE_ADDRESSWIDTH-1:0] A_STATUS = SLAVE_ADDRESSWIDTH'(1);
  localparam logic [SLAVE_ADDRESSWIDTH-1:0] A_BASE   = SLAVE_ADDRESSWIDTH'(2);
  localparam logic [SLAVE_ADDRESSWIDTH-1:0] A_STRIDE = SLAVE_ADDRESSWIDTH'(3);
  localparam logic [SLAVE_ADDRESSWIDTH-1:0] A_WIDTH  = SLAVE_ADDRESSWIDTH'(4);
  localparam logic [SLAVE_ADDRESSWIDTH-1:0] A_HEIGHT = SLAVE_ADDRESSWIDTH'(5);
  localparam logic [SLAVE_ADDRESSWIDTH-1:0] A_PIXEL  = SLAVE_ADDRESSWIDTH'(6);
  localparam logic [SLAVE_ADDRESSWIDTH-1:0] A_COUNT  = SLAVE_ADDRESSWIDTH'(7);

  state_t state_q, state_d;

  // Host-visible CSRs
  logic                           irq_en_q, done_q, grad_q;
  logic [MASTER_ADDRESSWIDTH-1:0] base_q, stride_q;
  logic [DIMWIDTH-1:0]            width_q, height_q;
  logic [DATAWIDTH-1:0]           pixel_q, count_q, readdata_q;

  // Working copies latched at START so host writes cannot disturb a fill
  logic [MASTER_ADDRESSWIDTH-1:0] row_base_q, stride_wk_q;
  logic [DIMWIDTH-1:0]            w_wk_q, h_wk_q, x_q, y_q;
  logic [DATAWIDTH-1:0]           pix_wk_q;
  logic                           grad_wk_q, abort_pend_q;

  logic csr_wr, csr_rd, start_req, abort_req, start_go, zero_size, accept, last_beat;

  assign csr_wr    = slave_write & slave_chipselect;
  assign csr_rd    = slave_read & slave_chipselect;
  assign start_req = csr_wr && (slave_address == A_CTRL) && slave_writedata[0];
  assign abort_req = csr_wr && (slave_address == A_CTRL) && slave_writedata[1];
  assign start_go  = start_req && (state_q == S_IDLE);
  assign zero_size = (width_q == '0) || (height_q == '0);
  assign accept    = master_write & ~master_waitrequest;
  assign last_beat = (x_q == w_wk_q - DIMWIDTH'(1)) && (y_q == h_wk_q - DIMWIDTH'(1));

`ifdef GRADIENT_FILL_EN
  assign master_writedata = grad_wk_q
                          ? pix_wk_q + DATAWIDTH'(x_q) + (DATAWIDTH'(y_q) << 8)
                          : pix_wk_q;
`else
  assign master_writedata = pix_wk_q;
`endif

  assign master_address = row_base_q
                        + MASTER_ADDRESSWIDTH'(x_q) * MASTER_ADDRESSWIDTH'(BYTES_PER_BEAT);
  assign slave_readdata = readdata_q;
  assign irq            = done_q & irq_en_q;
  assign busy           = (state_q != S_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    master_write = 1'b0;
    case (state_q)
      S_IDLE:   if (start_go && !zero_size) state_d = S_WRITE;
      S_WRITE: begin
        master_write = 1'b1;
        if (!master_waitrequest && (abort_pend_q || last_beat)) state_d = S_FINISH;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en_q     <= 1'b0;
      grad_q       <= 1'b0;
      done_q       <= 1'b0;
      base_q       <= '0;
      stride_q     <= '0;
      width_q      <= '0;
      height_q     <= '0;
      pixel_q      <= '0;
      count_q      <= '0;
      readdata_q   <= '0;
      row_base_q   <= '0;
      stride_wk_q  <= '0;
      w_wk_q       <= '0;
      h_wk_q       <= '0;
      x_q          <= '0;
      y_q          <= '0;
      pix_wk_q     <= '0;
      grad_wk_q    <= 1'b0;
      abort_pend_q <= 1'b0;
    end else begin
      if (csr_wr) begin
        case (slave_address)
          A_CTRL: begin
            irq_en_q <= slave_writedata[2];
`ifdef GRADIENT_FILL_EN
            grad_q   <= slave_writedata[3];
`endif
          end
          A_BASE:   base_q   <= slave_writedata[MASTER_ADDRESSWIDTH-1:0];
          A_STRIDE: stride_q <= slave_writedata[MASTER_ADDRESSWIDTH-1:0];
          A_WIDTH:  width_q  <= slave_writedata[DIMWIDTH-1:0];
          A_HEIGHT: height_q <= slave_writedata[DIMWIDTH-1:0];
          A_PIXEL:  pixel_q  <= slave_writedata;
          default: ;
        endcase
      end

      // FINISH and zero-size START set DONE; the set beats a same-cycle W1C
      if ((state_q == S_FINISH) || (start_go && zero_size))
        done_q <= 1'b1;
      else if (start_go || (csr_wr && (slave_address == A_STATUS) && slave_writedata[1]))
        done_q <= 1'b0;

      if (start_go)    count_q <= '0;
      else if (accept) count_q <= count_q + DATAWIDTH'(1);

      if (state_q != S_WRITE) abort_pend_q <= 1'b0;
      else if (abort_req)     abort_pend_q <= 1'b1;

      if (start_go) begin
        row_base_q  <= base_q;
        stride_wk_q <= stride_q;
        w_wk_q      <= width_q;
        h_wk_q      <= height_q;
        pix_wk_q    <= pixel_q;
        grad_wk_q   <= grad_q;
        x_q         <= '0;
        y_q         <= '0;
      end else if (accept) begin
        if (x_q == w_wk_q - DIMWIDTH'(1)) begin
          x_q        <= '0;
          y_q        <= y_q + DIMWIDTH'(1);
          row_base_q <= row_base_q + stride_wk_q;
        end else begin
          x_q <= x_q + DIMWIDTH'(1);
        end
      end

      if (csr_rd) begin
        case (slave_address)
          A_CTRL:   readdata_q <= DATAWIDTH'({grad_q, irq_en_q, 2'b00});
          A_STATUS: readdata_q <= DATAWIDTH'({done_q, busy});
          A_BASE:   readdata_q <= DATAWIDTH'(base_q);
          A_STRIDE: readdata_q <= DATAWIDTH'(stride_q);
          A_WIDTH:  readdata_q <= DATAWIDTH'(width_q);
          A_HEIGHT: readdata_q <= DATAWIDTH'(height_q);
          A_PIXEL:  readdata_q <= pixel_q;
          A_COUNT:  readdata_q <= count_q;
          default:  readdata_q <= '0;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_avmm_frame_writer.sv
// Scoreboard bench for avmm_frame_writer: expected beats/readdata queued by stimulus, checked by a monitor.
`default_nettype none

module tb_avmm_frame_writer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  slave_address = '0;
  logic [31:0] slave_writedata = '0;
  logic        slave_write = 1'b0;
  logic        slave_read = 1'b0;
  logic        slave_chipselect = 1'b0;
  logic [31:0] slave_readdata;
  logic [31:0] master_address;
  logic [31:0] master_writedata;
  logic        master_write;
  logic        master_waitrequest = 1'b0;
  logic        irq;
  logic        busy;

  always #5 clk = ~clk;

  avmm_frame_writer dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .slave_address      (slave_address),
    .slave_writedata    (slave_writedata),
    .slave_write        (slave_write),
    .slave_read         (slave_read),
    .slave_chipselect   (slave_chipselect),
    .slave_readdata     (slave_readdata),
    .master_address     (master_address),
    .master_writedata   (master_writedata),
    .master_write       (master_write),
    .master_waitrequest (master_waitrequest),
    .irq                (irq),
    .busy               (busy)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] exp_rd_q[$];
  string       exp_rd_name[$];
  int          tests = 0;
  int          fails = 0;
  int          n_acc = 0;
  bit          rd_pend = 0;

  localparam logic [2:0] CTRL = 3'd0, STATUS = 3'd1, BASE = 3'd2, STRIDE = 3'd3,
                         WIDTH = 3'd4, HEIGHT = 3'd5, PIXEL = 3'd6, COUNT = 3'd7;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    beat_t e;
    if (rd_pend) begin
      if (exp_rd_q.size() == 0) begin
        chk("rd_queue_empty", 32'd1, 32'd0);
      end else begin
        chk(exp_rd_name.pop_front(), slave_readdata, exp_rd_q.pop_front());
      end
    end
    rd_pend = slave_read && slave_chipselect;
    if (master_write) begin
      if (exp_q.size() == 0) begin
        if (!master_waitrequest) chk("unexpected_beat", master_address, 32'hFFFF_FFFF);
      end else if (master_waitrequest) begin
        chk("stall_addr", master_address, exp_q[0].addr);
        chk("stall_data", master_writedata, exp_q[0].data);
      end else begin
        e = exp_q.pop_front();
        chk("beat_addr", master_address, e.addr);
        chk("beat_data", master_writedata, e.data);
        n_acc++;
      end
    end
  end

  task automatic push_beat(input logic [31:0] a, input logic [31:0] d);
    beat_t b;
    b.addr = a;
    b.data = d;
    exp_q.push_back(b);
  endtask

  task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
    slave_address = a; slave_writedata = d; slave_write = 1'b1; slave_chipselect = 1'b1;
    @(posedge clk); #1;
    slave_write = 1'b0; slave_chipselect = 1'b0;
  endtask

  task automatic csr_rd(input logic [2:0] a, input logic [31:0] exp, input string name);
    exp_rd_q.push_back(exp);
    exp_rd_name.push_back(name);
    slave_address = a; slave_read = 1'b1; slave_chipselect = 1'b1;
    @(posedge clk); #1;
    slave_read = 1'b0; slave_chipselect = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_acc(input int k);
    for (int i = 0; i < 500; i++) begin
      if (n_acc >= k) break;
      @(posedge clk); #1;
    end
    if (n_acc < k) chk("wait_acc_timeout", n_acc, k);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 500; i++) begin
      if (!busy) break;
      @(posedge clk); #1;
    end
    chk("busy_after_fill", {31'd0, busy}, 32'd0);
    idle(2);
    chk("beats_missing", exp_q.size(), 32'd0);
  endtask

  task automatic setup(input logic [31:0] b, input logic [31:0] s, input logic [31:0] w,
                       input logic [31:0] h, input logic [31:0] p);
    csr_wr(BASE, b); csr_wr(STRIDE, s); csr_wr(WIDTH, w); csr_wr(HEIGHT, h); csr_wr(PIXEL, p);
  endtask

  task automatic push_basic();
    push_beat(32'h0800_0000, 32'h0000_FF00);
    push_beat(32'h0800_0004, 32'h0000_FF00);
    push_beat(32'h0800_0008, 32'h0000_FF00);
    push_beat(32'h0800_0010, 32'h0000_FF00);
    push_beat(32'h0800_0014, 32'h0000_FF00);
    push_beat(32'h0800_0018, 32'h0000_FF00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    idle(3);
    chk("reset_master_write", {31'd0, master_write}, 32'd0);
    chk("reset_irq", {31'd0, irq}, 32'd0);
    chk("reset_master_address", master_address, 32'd0);
    reset_n = 1'b1;
    idle(1);
    csr_rd(STATUS, 32'd0, "reset_status");
    csr_rd(COUNT, 32'd0, "reset_count");

    // CSR read-back and dimension truncation
    csr_wr(BASE, 32'h0800_0000);
    csr_rd(BASE, 32'h0800_0000, "base_rb");
    csr_wr(WIDTH, 32'hFFFF_FFFF);
    csr_rd(WIDTH, 32'h0000_07FF, "width_trunc");

    // Basic 3x2 fill
    setup(32'h0800_0000, 32'h10, 32'd3, 32'd2, 32'h0000_FF00);
    push_basic();
    csr_wr(CTRL, 32'h1);
    csr_rd(CTRL, 32'h0, "ctrl_start_reads0");
    wait_idle();
    csr_rd(STATUS, 32'h2, "basic_status");
    csr_rd(COUNT, 32'd6, "basic_count");

    // Same fill with a 3-cycle stall on beat 2
    base = n_acc;
    push_basic();
    csr_wr(CTRL, 32'h1);
    wait_acc(base + 2);
    master_waitrequest = 1'b1;
    idle(3);
    master_waitrequest = 1'b0;
    wait_idle();
    csr_rd(COUNT, 32'd6, "stall_count");

    // Abort while the 11th beat is stalled
    setup(32'h0000_1000, 32'h0, 32'd100, 32'd1, 32'h0000_ABCD);
    for (int i = 0; i < 11; i++) push_beat(32'h0000_1000 + 32'(4 * i), 32'h0000_ABCD);
    base = n_acc;
    csr_wr(CTRL, 32'h1);
    wait_acc(base + 10);
    master_waitrequest = 1'b1;
    csr_wr(CTRL, 32'h2);
    idle(2);
    master_waitrequest = 1'b0;
    wait_idle();
    csr_rd(STATUS, 32'h2, "abort_status");
    csr_rd(COUNT, 32'd11, "abort_count");

    // Zero height: DONE without beats
    csr_wr(STATUS, 32'h2);
    csr_rd(STATUS, 32'h0, "w1c_status");
    setup(32'h0000_5000, 32'h0, 32'd5, 32'd0, 32'h1);
    csr_wr(CTRL, 32'h1);
    csr_rd(STATUS, 32'h2, "zero_status");
    csr_rd(COUNT, 32'd0, "zero_count");

    // START and WIDTH writes during a fill are ignored
    setup(32'h0000_4000, 32'h0, 32'd20, 32'd1, 32'h55);
    for (int i = 0; i < 20; i++) push_beat(32'h0000_4000 + 32'(4 * i), 32'h55);
    csr_wr(CTRL, 32'h1);
    csr_wr(WIDTH, 32'd8);
    csr_wr(CTRL, 32'h1);
    wait_idle();
    csr_rd(COUNT, 32'd20, "restart_count");

    // IRQ follows DONE & IRQ_EN
    csr_wr(CTRL, 32'h4);
    chk("irq_set", {31'd0, irq}, 32'd1);
    csr_rd(CTRL, 32'h4, "ctrl_irq_en");
    csr_wr(STATUS, 32'h2);
    chk("irq_clear", {31'd0, irq}, 32'd0);

    // GRAD bit and 2x2 fill data
    csr_wr(CTRL, 32'hC);
`ifdef GRADIENT_FILL_EN
    csr_rd(CTRL, 32'hC, "ctrl_grad");
    push_beat(32'h2000, 32'h10); push_beat(32'h2004, 32'h11);
    push_beat(32'h2100, 32'h110); push_beat(32'h2104, 32'h111);
`else
    csr_rd(CTRL, 32'h4, "ctrl_grad");
    push_beat(32'h2000, 32'h10); push_beat(32'h2004, 32'h10);
    push_beat(32'h2100, 32'h10); push_beat(32'h2104, 32'h10);
`endif
    setup(32'h2000, 32'h100, 32'd2, 32'd2, 32'h10);
    csr_wr(CTRL, 32'hD);
    wait_idle();
    chk("irq_after_grad", {31'd0, irq}, 32'd1);

    // Asynchronous reset mid-fill
    setup(32'h0000_3000, 32'h0, 32'd50, 32'd1, 32'h77);
    for (int i = 0; i < 50; i++) push_beat(32'h0000_3000 + 32'(4 * i), 32'h77);
    base = n_acc;
    csr_wr(CTRL, 32'h1);
    wait_acc(base + 5);
    chk("write_before_reset", {31'd0, master_write}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("reset_drops_write", {31'd0, master_write}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    exp_q.delete();
    idle(2);
    reset_n = 1'b1;
    idle(1);
    csr_rd(STATUS, 32'h0, "post_reset_status");
    csr_rd(COUNT, 32'h0, "post_reset_count");
    csr_rd(BASE, 32'h0, "post_reset_base");
    idle(3);
    chk("reads_outstanding", exp_rd_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
